// File: rtl/mode_sequencer.sv
// Front-panel controller: debounced active-low button steps an N-mode selection
// (short = forward, long = back) and runs a start/done handshake with the engine.
module mode_sequencer #(
    parameter int N_MODES           = 16,
    parameter int RESET_MODE        = 14,
    parameter int DEBOUNCE_CYCLES   = 20,
    parameter int LONG_PRESS_CYCLES = 12000,
    parameter int AUTOSTART_DELAY   = 10,
    parameter int TIMEOUT_CYCLES    = 4096,
    parameter int RESULT_W          = 8,
    parameter int MODE_W            = $clog2(N_MODES)
) (
    input  logic                WF_CLK,
    input  logic                rst_n,
    input  logic                WF_BUTTON,
    output logic [MODE_W-1:0]   mode,
    output logic                start,
    output logic                abort,
    input  logic                done,
    input  logic [RESULT_W-1:0] result,
    output logic [RESULT_W-1:0] led_out,
    output logic                valid,
    output logic                err,
    output logic                pressed
);
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
    localparam int WAIT_W = $clog2(AUTOSTART_DELAY + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(AUTOSTART_DELAY - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(N_MODES - 1);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_START, S_RUN, S_HOLD} state_t;

    logic                sync_a, sync_b;
    logic [DB_W-1:0]     db_cnt;
    logic                db_fire;
    logic [HOLD_W-1:0]   hold_cnt;
    logic                released;
    logic                mode_chg;
    state_t              state, state_nxt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [TO_W-1:0]     to_cnt;
    logic                run_done, run_timeout;
    logic                start_nxt, abort_nxt, valid_nxt, err_nxt;
    logic [RESULT_W-1:0] led_nxt;

    // Synchroniser flops hold the inverted button, so 0 means released.
    assign db_fire = (sync_b != pressed) && (db_cnt == DB_LAST);

    always_ff @(posedge WF_CLK) begin
        if (!rst_n) begin
            sync_a   <= 1'b0;
            sync_b   <= 1'b0;
            db_cnt   <= '0;
            pressed  <= 1'b0;
            hold_cnt <= '0;
            released <= 1'b0;
        end else begin
            sync_a   <= ~WF_BUTTON;
            sync_b   <= sync_a;
            released <= db_fire && !sync_b;
            if (sync_b == pressed || db_fire) begin
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
            if (db_fire) begin
                pressed <= sync_b;
            end
            if (db_fire && sync_b) begin
                hold_cnt <= '0;
            end else if (pressed && hold_cnt != HOLD_MAX) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end
        end
    end

    always_ff @(posedge WF_CLK) begin
        if (!rst_n) begin
            mode     <= MODE_W'(RESET_MODE);
            mode_chg <= 1'b0;
        end else begin
            mode_chg <= released;
            if (released) begin
                if (hold_cnt < HOLD_MAX) begin
                    mode <= (mode == MODE_LAST) ? '0 : mode + MODE_W'(1);
                end else begin
                    mode <= (mode == '0) ? MODE_LAST : mode - MODE_W'(1);
                end
            end
        end
    end

    // A pending mode change outranks both completion and timeout in RUN.
    assign run_done    = (state == S_RUN) && done && !mode_chg;
    assign run_timeout = (state == S_RUN) && !done && !mode_chg && (to_cnt == TO_LAST);

    always_ff @(posedge WF_CLK) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            to_cnt   <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= (state == S_WAIT && !mode_chg) ? wait_cnt + WAIT_W'(1) : '0;
            to_cnt   <= (state == S_RUN) ? to_cnt + TO_W'(1) : '0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = S_WAIT;
            S_WAIT:  if (!mode_chg && wait_cnt == WAIT_LAST) state_nxt = S_START;
            S_START: state_nxt = mode_chg ? S_WAIT : S_RUN;
            S_RUN: begin
                if (mode_chg) begin
                    state_nxt = S_WAIT;
                end else if (run_done || run_timeout) begin
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD:  if (mode_chg) state_nxt = S_WAIT;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        start_nxt = (state == S_START) && !mode_chg;
        abort_nxt = (state == S_RUN) && mode_chg;
        led_nxt   = led_out;
        valid_nxt = valid;
        err_nxt   = err;
        if (mode_chg) begin
            valid_nxt = 1'b0;
        end else if (run_done) begin
            led_nxt   = result;
            valid_nxt = 1'b1;
            err_nxt   = 1'b0;
        end else if (run_timeout) begin
            led_nxt   = '1;
            valid_nxt = 1'b0;
            err_nxt   = 1'b1;
        end
    end

    always_ff @(posedge WF_CLK) begin
        if (!rst_n) begin
            start   <= 1'b0;
            abort   <= 1'b0;
            led_out <= '0;
            valid   <= 1'b0;
            err     <= 1'b0;
        end else begin
            start   <= start_nxt;
            abort   <= abort_nxt;
            led_out <= led_nxt;
            valid   <= valid_nxt;
            err     <= err_nxt;
        end
    end
endmodule

// File: tb/tb_mode_sequencer.sv
// Bench for mode_sequencer: stimulus tasks push timestamped output snapshots,
// a monitor pops one whenever any DUT output changes and compares it.
module tb_mode_sequencer;
    localparam int N_MODES    = 16;
    localparam int RESET_MODE = 14;
    localparam int DEB        = 20;
    localparam int LONG       = 12000;
    localparam int DLY        = 10;
    localparam int TMO        = 4096;
    localparam int RW         = 8;
    localparam int MW         = 4;

    logic          WF_CLK    = 1'b0;
    logic          rst_n     = 1'b0;
    logic          WF_BUTTON = 1'b1;
    logic          done      = 1'b0;
    logic [RW-1:0] result    = '0;
    logic [MW-1:0] mode;
    logic          start, abort, valid, err, pressed;
    logic [RW-1:0] led_out;

    mode_sequencer #(
        .N_MODES(N_MODES), .RESET_MODE(RESET_MODE), .DEBOUNCE_CYCLES(DEB),
        .LONG_PRESS_CYCLES(LONG), .AUTOSTART_DELAY(DLY), .TIMEOUT_CYCLES(TMO),
        .RESULT_W(RW), .MODE_W(MW)
    ) dut (
        .WF_CLK(WF_CLK), .rst_n(rst_n), .WF_BUTTON(WF_BUTTON), .mode(mode),
        .start(start), .abort(abort), .done(done), .result(result),
        .led_out(led_out), .valid(valid), .err(err), .pressed(pressed)
    );

    always #5 WF_CLK = ~WF_CLK;

    int cyc = 0;
    always @(posedge WF_CLK) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic [MW-1:0] mode;
        logic          st;
        logic          ab;
        logic [RW-1:0] led;
        logic          vld;
        logic          er;
        logic          prs;
    } snap_t;

    snap_t         expq[$];
    snap_t         m_last;
    int            m_mode;
    logic [RW-1:0] m_led;
    logic          m_valid, m_err, m_pressed, m_start, m_abort;
    bit            m_running = 1'b0;
    int            m_run_start = 0;
    int            n_cmp = 0;
    int            n_bad = 0;

    function automatic bit same_vals(snap_t a, snap_t b);
        return (a.mode === b.mode) && (a.st === b.st) && (a.ab === b.ab) &&
               (a.led === b.led) && (a.vld === b.vld) && (a.er === b.er) &&
               (a.prs === b.prs);
    endfunction

    // Record the model's output state as of edge c; same-edge updates merge.
    function automatic void ev(int c);
        snap_t s;
        s.cyc = c; s.mode = MW'(m_mode); s.st = m_start; s.ab = m_abort;
        s.led = m_led; s.vld = m_valid; s.er = m_err; s.prs = m_pressed;
        if (expq.size() > 0 && expq[expq.size()-1].cyc == c) expq[expq.size()-1] = s;
        else if (!same_vals(s, m_last)) expq.push_back(s);
        m_last = s;
    endfunction

    initial begin
        snap_t prev, cur, e;
        forever begin
            @(negedge WF_CLK);
            cur.cyc = cyc; cur.mode = mode; cur.st = start; cur.ab = abort;
            cur.led = led_out; cur.vld = valid; cur.er = err; cur.prs = pressed;
            if (!same_vals(cur, prev)) begin
                n_cmp++;
                if (expq.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_change@%0d got mode=%0d start=%b abort=%b led=%h valid=%b err=%b pressed=%b required no change",
                             cyc, cur.mode, cur.st, cur.ab, cur.led, cur.vld, cur.er, cur.prs);
                end else begin
                    e = expq.pop_front();
                    if (e.cyc != cyc || !same_vals(cur, e)) begin
                        n_bad++;
                        $display("FAIL event@%0d got mode=%0d start=%b abort=%b led=%h valid=%b err=%b pressed=%b required @%0d mode=%0d start=%b abort=%b led=%h valid=%b err=%b pressed=%b",
                                 cyc, cur.mode, cur.st, cur.ab, cur.led, cur.vld, cur.er, cur.prs,
                                 e.cyc, e.mode, e.st, e.ab, e.led, e.vld, e.er, e.prs);
                    end
                end
            end
            prev = cur;
        end
    end

    initial begin
        #(90000 * 10);
        $display("FAIL watchdog cycle=%0d required finish before 90000", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic tick_to(input int c);
        while (cyc < c) begin
            @(posedge WF_CLK);
            #1;
        end
    endtask

    task automatic expect_start(input int s);
        m_start = 1'b1; ev(s);
        m_start = 1'b0; ev(s + 1);
        m_running   = 1'b1;
        m_run_start = s;
    endtask

    task automatic do_reset(input int hold);
        int r = cyc;
        rst_n = 1'b0; WF_BUTTON = 1'b1; done = 1'b0;
        m_mode = RESET_MODE; m_led = '0; m_valid = 1'b0; m_err = 1'b0;
        m_pressed = 1'b0; m_start = 1'b0; m_abort = 1'b0; m_running = 1'b0;
        ev(r + 1);
        tick_to(r + hold);
        rst_n = 1'b1;
        expect_start(r + hold + DLY + 2);
        tick_to(r + hold + DLY + 3);
    endtask

    task automatic engine_done(input int k, input logic [RW-1:0] res);
        int e = m_run_start + k;
        tick_to(e - 1);
        done = 1'b1; result = res;
        m_led = res; m_valid = 1'b1; m_err = 1'b0; m_running = 1'b0;
        ev(e);
        tick_to(e);
        done = 1'b0; result = RW'($urandom);
    endtask

    task automatic engine_timeout();
        int e = m_run_start + TMO;
        m_led = '1; m_valid = 1'b0; m_err = 1'b1; m_running = 1'b0;
        ev(e);
        tick_to(e + 1);
    endtask

    task automatic stray_done(input int len);
        int n0 = cyc;
        done = 1'b1; result = RW'($urandom);
        tick_to(n0 + len);
        done = 1'b0;
        tick_to(n0 + len + 4);
    endtask

    task automatic glitch(input int g);
        int n0 = cyc;
        WF_BUTTON = 1'b0;
        tick_to(n0 + g);
        WF_BUTTON = 1'b1;
        tick_to(n0 + g + DEB + 6);
    endtask

    // Button held for h cycles; collide puts done on the edge where the mode change lands.
    task automatic press(input int h, input bit collide);
        int n0  = cyc;
        int rel = n0 + h + 2 + DEB;
        int f   = rel + 2;
        WF_BUTTON = 1'b0;
        m_pressed = 1'b1; ev(n0 + 2 + DEB);
        m_pressed = 1'b0; ev(rel);
        if (h >= LONG) m_mode = (m_mode + N_MODES - 1) % N_MODES;
        else           m_mode = (m_mode + 1) % N_MODES;
        ev(rel + 1);
        m_valid = 1'b0;
        if (m_running) begin
            m_abort = 1'b1; ev(f);
            m_abort = 1'b0; ev(f + 1);
        end else begin
            ev(f);
        end
        expect_start(f + DLY + 1);
        tick_to(n0 + h);
        WF_BUTTON = 1'b1;
        if (collide) begin
            tick_to(f - 1);
            done = 1'b1; result = RW'($urandom);
            tick_to(f);
            done = 1'b0;
        end
        tick_to(f + DLY + 2);
    endtask

    task automatic reset_mid_press();
        int n0 = cyc;
        WF_BUTTON = 1'b0;
        m_pressed = 1'b1; ev(n0 + 2 + DEB);
        tick_to(n0 + 2 + DEB + 5);
        do_reset(1);
    endtask

    initial begin
        do_reset(2);
        engine_done(10, 8'hA5);
        press(50, 1'b0);
        press(50, 1'b0);
        engine_done(5, 8'h3C);
        press(13000, 1'b0);
        engine_done(7, 8'h11);
        glitch(12);
        glitch(DEB - 1);
        press(30, 1'b0);
        press(40, 1'b1);
        engine_timeout();
        press(25, 1'b0);
        engine_done(20, 8'h5A);
        press(25, 1'b0);
        reset_mid_press();
        engine_done(6, 8'h77);
        press(LONG - 1, 1'b0);
        engine_done(4, 8'h42);
        press(LONG, 1'b0);
        for (int i = 0; i < 16; i++) begin
            if (m_running) begin
                case ($urandom_range(0, 2))
                    0:       engine_done($urandom_range(3, 60), RW'($urandom));
                    1:       press($urandom_range(DEB + 2, 150), 1'($urandom_range(0, 1)));
                    default: engine_done($urandom_range(3, 8), RW'($urandom));
                endcase
            end else begin
                case ($urandom_range(0, 2))
                    0:       press($urandom_range(DEB + 2, 150), 1'b0);
                    1:       glitch($urandom_range(1, DEB - 1));
                    default: stray_done($urandom_range(1, 5));
                endcase
            end
        end
        if (m_running) engine_done(5, RW'($urandom));
        tick_to(cyc + 40);
        n_cmp++;
        if (expq.size() != 0) begin
            n_bad++;
            $display("FAIL leftover_events got=%0d required=0", expq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
